// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family: count modes, directions
// and the run/halt controller states.
package counter_pkg;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage : counter_pkg

// File: rtl/mod_step.sv
// Combinational modulo step: next count value in the requested direction and
// terminal-value detect. Also used as a digit slice by the BCD cascade.
module mod_step
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q_next,
    output logic             at_tv
);

    localparam logic [WIDTH:0] TOP_EXT = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    logic [WIDTH:0] q_inc;
    logic [WIDTH:0] q_dec;
    logic [WIDTH:0] q_sel;
    logic           unused_msb;

    assign q_ext = {1'b0, q};
    assign q_inc = q_ext + (WIDTH+1)'(1);
    assign q_dec = q_ext - (WIDTH+1)'(1);

    always_comb begin
        at_tv = 1'b0;
        q_sel = q_ext;
        if (up_dn == DIR_UP) begin
            at_tv = (q_ext == TOP_EXT);
            q_sel = at_tv ? '0 : q_inc;
        end else begin
            at_tv = (q_ext == '0);
            q_sel = at_tv ? TOP_EXT : q_dec;
        end
    end

    // Top bit is always clear for any in-range q; kept only so the step
    // never overflows internally.
    assign unused_msb = q_sel[WIDTH];
    assign q_next     = q_sel[WIDTH-1:0];

endmodule : mod_step

// File: rtl/mod_updown_counter.sv
// Parametrised synchronous up/down modulo counter with clear, parallel load,
// wrap/one-shot modes and terminal-count / wrap / done / load-error status.
//
// state   | meaning
// ST_RUN  | counting allowed whenever en=1
// ST_HALT | one-shot reached its terminal value; q frozen until clear/load
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] Q_RST   = WIDTH'(RESET_VAL);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic             wrap_n;
    logic             done_n;
    logic             load_err_n;
    logic [WIDTH-1:0] step_q;
    logic             step_tv;
    logic             load_ok;

    mod_step #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_step (
        .q      (q),
        .up_dn  (up_dn),
        .q_next (step_q),
        .at_tv  (step_tv)
    );

    // Compare in WIDTH+1 bits so MODULUS = 2**WIDTH is representable.
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    assign tc = en & step_tv & (state == ST_RUN);

    always_comb begin
        state_n    = state;
        q_n        = q;
        wrap_n     = 1'b0;
        done_n     = done;
        load_err_n = 1'b0;
        if (clear) begin
            q_n     = '0;
            done_n  = 1'b0;
            state_n = ST_RUN;
        end else if (load) begin
            q_n        = load_ok ? load_val : Q_TOP;
            load_err_n = ~load_ok;
            done_n     = 1'b0;
            state_n    = ST_RUN;
        end else if (en && state == ST_RUN) begin
            if (step_tv && mode == MODE_ONESHOT) begin
                done_n  = 1'b1;
                state_n = ST_HALT;
            end else begin
                q_n    = step_q;
                wrap_n = step_tv;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            q        <= Q_RST;
            wrap     <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_n;
            q        <= q_n;
            wrap     <= wrap_n;
            done     <= done_n;
            load_err <= load_err_n;
        end
    end

endmodule : mod_updown_counter

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised synchronous up/down counter.
- Successor to the 4-bit T-flip-flop ripple counter, used for event counting, clock-division tick generation and timeouts in the digital-electronics lab designs.
- Adds programmable width and modulus, count direction, clock enable, parallel load, synchronous clear and wrap/one-shot modes.
- Adds terminal-count and wrap status outputs.
- All state is clocked on one edge of one clock, so there is no ripple skew.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..32.
- MODULUS, 16: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- RESET_VAL, 0: value of q after reset; must be < MODULUS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset; forces all state to reset values immediately.
- en  in  1  count enable; when 0, q holds (load and clear still act).
- up_dn  in  1  direction: 1 = count up, 0 = count down.
- mode  in  1  0 = WRAP (free-running modulo count), 1 = ONESHOT (stop at terminal value).
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count.
- tc  out  1  terminal count, combinational.
- wrap  out  1  registered one-cycle pulse.
- done  out  1  registered, sticky; ONESHOT completion.
- load_err  out  1  registered one-cycle pulse; out-of-range load.

Behaviour:
- Reset (async, active-high) forces:
  - q = RESET_VAL
  - wrap = 0, done = 0, load_err = 0
  - FSM state = RUN
- Reset deasserts synchronously to clk (deassertion synchroniser is owned by the top level).
- Priority per rising edge: reset > clear > load > count (en).
- clear:
  - q <= 0; done <= 0; FSM -> RUN.
  - load and en are ignored that cycle.
- load:
  - if load_val < MODULUS: q <= load_val.
  - else: q <= MODULUS-1 and load_err pulses high for exactly one cycle.
  - Always: done <= 0; FSM -> RUN.
  - The count step is suppressed in the load cycle.
- Terminal value: TV = MODULUS-1 when up_dn=1, 0 when up_dn=0.
- tc = en & (q == TV) & (state == RUN). tc is combinational, with zero latency.
- Count when en=1, state=RUN, and no clear/load:
  - up, q != MODULUS-1: q <= q+1.
  - down, q != 0: q <= q-1.
  - at TV in WRAP mode: q <= 0 (up) or MODULUS-1 (down); wrap <= 1 for one cycle.
  - at TV in ONESHOT mode: q holds TV; done <= 1; FSM -> HALT; wrap stays 0.
- FSM states: RUN, HALT.
  - RUN -> HALT: ONESHOT terminal step, as above.
  - HALT -> RUN: only on clear, load or reset.
  - In HALT, en is ignored and q holds.
- Live inputs: a change of mode or up_dn while in RUN takes effect on the next edge; no glitch on q.
- mode=0 while in HALT does not leave HALT.
- Width rules:
  - Arithmetic uses WIDTH+1 bits internally; no intermediate overflow.
  - For MODULUS = 2**WIDTH, modulo wrap equals natural binary wrap.
- Latency:
  - q updates one cycle after the qualifying edge.
  - wrap, done and load_err are asserted in the same cycle q takes its new value.
- Simultaneous events: load and clear in the same cycle: clear wins, and load_err is not raised.

Decomposition:
- Shared package `counter_pkg`:
  - Mode encoding constants: MODE_WRAP = 1'b0, MODE_ONESHOT = 1'b1.
  - FSM state encoding: ST_RUN, ST_HALT.
  - DIR_UP / DIR_DOWN constants.
- Optional sub-module `mod_step`: combinational next-value and terminal detect (inputs q, up_dn; outputs q_next, at_tv), parametrised by WIDTH and MODULUS. It is reused by the planned multi-digit BCD cascade.
- Registers, FSM and priority logic live in the top module.

Test Plan:
- WRAP up, defaults (W=4, M=16), en=1 for 18 cycles from reset:
  - q sequence 0..15,0,1.
  - tc high only while q=15.
  - wrap pulses once, in the cycle q becomes 0.
- MODULUS=10, down, WRAP, start from load_val=2:
  - q = 2,1,0,9,8.
  - wrap pulses when q becomes 9.
  - load_val=12 -> q=9 and load_err=1 for exactly one cycle.
- ONESHOT up, M=10, load 7:
  - q = 7,8,9 then holds at 9.
  - done=1 and sticky; tc drops to 0 after HALT.
  - Further en cycles leave q=9.
  - A load of 3 restarts counting and clears done.
- Priority: assert clear, load (load_val=5) and en together at q=6 -> q=0, load_err=0, wrap=0.
- Async reset mid-count (q=11, up, WRAP), reset pulsed between clock edges:
  - q goes to RESET_VAL immediately, without waiting for clk.
  - done and wrap go to 0.
  - After release, counting resumes from RESET_VAL on the next enabled edge.
- en=0 for 5 cycles at q=4 with direction toggling -> q stays 4, tc=0; resuming down gives q=3.
